// File: rtl/axis_packet_mux_n.sv
// N-input AXI-Stream packet multiplexer. It forwards whole packets from one granted input,
// chosen by a config-selected or round-robin arbiter, through a 2-entry registered skid buffer.
module axis_packet_mux_n #(
    parameter int NUM_CH              = 4,
    parameter int DATA_WIDTH_IN_BYTES = 4,
    parameter int ARB_MODE            = 0,
    localparam int DW                 = 8 * DATA_WIDTH_IN_BYTES,
    localparam int CH_W               = $clog2(NUM_CH)
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [7:0]             s_axis_tdata_sel,
    input  logic                   s_axis_tvalid_sel,
    output logic                   s_axis_tready_sel,
    input  logic [NUM_CH*DW-1:0]   s_axis_tdata,
    input  logic [NUM_CH-1:0]      s_axis_tvalid,
    input  logic [NUM_CH-1:0]      s_axis_tlast,
    output logic [NUM_CH-1:0]      s_axis_tready,
    output logic [DW-1:0]          m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   RDY,
    output logic                   busy,
    output logic [CH_W-1:0]        active_ch
);

    localparam logic [0:0]    ST_IDLE    = 1'b0;
    localparam logic [0:0]    ST_PASS    = 1'b1;
    localparam logic [7:0]    NUM_CH_SEL = 8'(NUM_CH);
    localparam logic [CH_W:0] NUM_CH_RR  = (CH_W+1)'(NUM_CH);

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [7:0]        r_select;
    logic [7:0]        w_select_next;
    logic              r_pend_valid;
    logic              w_pend_valid_next;
    logic [7:0]        r_pend_sel;
    logic [7:0]        w_pend_sel_next;
    logic              r_tready_sel;
    logic              r_rdy;
    logic [CH_W-1:0]   r_grant;
    logic [CH_W-1:0]   w_grant_next;
    logic [NUM_CH-1:0] r_s_tready;
    logic [NUM_CH-1:0] w_s_tready_next;
    logic [DW-1:0]     r_skid_data0;
    logic [DW-1:0]     r_skid_data1;
    logic              r_skid_last0;
    logic              r_skid_last1;
    logic [1:0]        r_skid_valid;
    logic [1:0]        w_skid_valid_next;

    logic [DW-1:0]     w_ch_data [NUM_CH];
    logic [CH_W-1:0]   w_sel_ch;
    logic              w_sel_ok;
    logic              w_in_fire;
    logic              w_in_last;
    logic [DW-1:0]     w_in_data;
    logic              w_out_fire;
    logic              w_rr_found;
    logic [CH_W-1:0]   w_rr_ch;
    logic [CH_W:0]     w_rr_sum;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_data
        assign w_ch_data[gi] = s_axis_tdata[gi*DW +: DW];
    end

    // The range test guards the one cycle where select has just changed but RDY has not caught up.
    assign w_sel_ch   = r_select[CH_W-1:0];
    assign w_sel_ok   = r_rdy && (r_select < NUM_CH_SEL);
    assign w_in_fire  = |(r_s_tready & s_axis_tvalid);
    assign w_in_last  = s_axis_tlast[r_grant];
    assign w_in_data  = w_ch_data[r_grant];
    assign w_out_fire = r_skid_valid[0] && m_axis_tready;

    // Scan from the farthest candidate to the nearest so the nearest valid channel wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_ch    = r_grant;
        w_rr_sum   = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_rr_sum = {1'b0, r_grant} + (CH_W+1)'(i);
            if (w_rr_sum >= NUM_CH_RR) begin
                w_rr_sum = w_rr_sum - NUM_CH_RR;
            end
            if (s_axis_tvalid[w_rr_sum[CH_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_ch    = w_rr_sum[CH_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_select_next     = r_select;
        w_grant_next      = r_grant;
        w_pend_valid_next = r_pend_valid;
        w_pend_sel_next   = r_pend_sel;
        if (ARB_MODE == 0 && s_axis_tvalid_sel && r_tready_sel) begin
            w_pend_valid_next = 1'b1;
            w_pend_sel_next   = s_axis_tdata_sel;
        end
        case (r_state)
            ST_IDLE: begin
                if (ARB_MODE == 0) begin
                    if (r_pend_valid) begin
                        w_select_next     = r_pend_sel;
                        w_pend_valid_next = 1'b0;
                    end else if (w_sel_ok && s_axis_tvalid[w_sel_ch]) begin
                        w_grant_next = w_sel_ch;
                        w_state_next = ST_PASS;
                    end
                end else if (w_rr_found) begin
                    w_grant_next = w_rr_ch;
                    w_state_next = ST_PASS;
                end
            end
            default: begin
                if (w_in_fire && w_in_last) begin
                    w_state_next = ST_IDLE;
                end
            end
        endcase
    end

    // Input ready is registered, so it is derived from the occupancy the skid will have next cycle.
    always_comb begin
        w_skid_valid_next = r_skid_valid;
        case ({w_in_fire, w_out_fire})
            2'b10: begin
                if (r_skid_valid[0]) begin
                    w_skid_valid_next[1] = 1'b1;
                end else begin
                    w_skid_valid_next[0] = 1'b1;
                end
            end
            2'b01:   w_skid_valid_next = {1'b0, r_skid_valid[1]};
            default: w_skid_valid_next = r_skid_valid;
        endcase
        w_s_tready_next = '0;
        if (w_state_next == ST_PASS && !(&w_skid_valid_next)) begin
            w_s_tready_next[w_grant_next] = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state      <= ST_IDLE;
            r_select     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_sel   <= '0;
            r_tready_sel <= 1'b0;
            r_rdy        <= 1'b1;
            r_grant      <= '0;
            r_s_tready   <= '0;
            r_skid_data0 <= '0;
            r_skid_data1 <= '0;
            r_skid_last0 <= 1'b0;
            r_skid_last1 <= 1'b0;
            r_skid_valid <= '0;
        end else begin
            r_state      <= w_state_next;
            r_select     <= w_select_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_sel   <= w_pend_sel_next;
            r_tready_sel <= (ARB_MODE != 0) ? 1'b1 : !w_pend_valid_next;
            r_rdy        <= (ARB_MODE != 0) ? 1'b1 : (r_select < NUM_CH_SEL);
            r_grant      <= w_grant_next;
            r_s_tready   <= w_s_tready_next;
            r_skid_valid <= w_skid_valid_next;
            if (w_in_fire) begin
                if (w_out_fire && r_skid_valid[1]) begin
                    r_skid_data0 <= r_skid_data1;
                    r_skid_last0 <= r_skid_last1;
                    r_skid_data1 <= w_in_data;
                    r_skid_last1 <= w_in_last;
                end else if (w_out_fire || !r_skid_valid[0]) begin
                    r_skid_data0 <= w_in_data;
                    r_skid_last0 <= w_in_last;
                end else begin
                    r_skid_data1 <= w_in_data;
                    r_skid_last1 <= w_in_last;
                end
            end else if (w_out_fire) begin
                r_skid_data0 <= r_skid_data1;
                r_skid_last0 <= r_skid_last1;
            end
        end
    end

    assign s_axis_tready_sel = r_tready_sel;
    assign s_axis_tready     = r_s_tready;
    assign m_axis_tdata      = r_skid_data0;
    assign m_axis_tvalid     = r_skid_valid[0];
    assign m_axis_tlast      = r_skid_last0;
    assign RDY               = r_rdy;
    assign busy              = (r_state == ST_PASS);
    assign active_ch         = r_grant;

endmodule

// File: tb/tb_axis_packet_mux_n.sv
// Bench for axis_packet_mux_n: a config-select instance and a round-robin instance.
// Per-channel packet queues feed the drivers, and an expected-beat scoreboard is checked by a monitor.
module tb_axis_packet_mux_n;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CHW = 2;

    logic clk    = 1'b0;
    bit   clk_en = 1'b1;
    logic rst_n  = 1'b0;
    bit   flush  = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    int   pkt_id = 0;

    logic [7:0]         sel_data [2];
    logic               sel_valid [2];
    logic               sel_ready [2];
    logic [NCH*DW-1:0]  s_tdata_f [2];
    logic [NCH-1:0]     s_tvalid_f [2];
    logic [NCH-1:0]     s_tlast_f [2];
    logic [NCH-1:0]     s_tready [2];
    logic [DW-1:0]      m_data [2];
    logic               m_valid [2];
    logic               m_last [2];
    logic               m_rdy [2];
    logic               rdy [2];
    logic               busy [2];
    logic [CHW-1:0]     act [2];

    logic [DW-1:0]      ch_data [2][NCH];
    logic               ch_valid [2][NCH];
    logic               ch_last [2][NCH];
    logic [DW:0]        expq [2][$];
    logic [DW:0]        chq [2][NCH][$];
    int                 gap_pct [2];
    int                 mrdy_mode [2];
    logic               prev_stall [2];
    logic [DW-1:0]      prev_data [2];
    logic               prev_last [2];

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            s_tdata_f[d]  = '0;
            s_tvalid_f[d] = '0;
            s_tlast_f[d]  = '0;
            for (int c = 0; c < NCH; c++) begin
                s_tdata_f[d][c*DW +: DW] = ch_data[d][c];
                s_tvalid_f[d][c]         = ch_valid[d][c];
                s_tlast_f[d][c]          = ch_last[d][c];
            end
        end
    end

    axis_packet_mux_n #(.NUM_CH(NCH), .DATA_WIDTH_IN_BYTES(4), .ARB_MODE(0)) u_sel (
        .ACLK(clk), .ARESETn(rst_n),
        .s_axis_tdata_sel(sel_data[0]), .s_axis_tvalid_sel(sel_valid[0]), .s_axis_tready_sel(sel_ready[0]),
        .s_axis_tdata(s_tdata_f[0]), .s_axis_tvalid(s_tvalid_f[0]), .s_axis_tlast(s_tlast_f[0]),
        .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tlast(m_last[0]),
        .m_axis_tready(m_rdy[0]),
        .RDY(rdy[0]), .busy(busy[0]), .active_ch(act[0])
    );

    axis_packet_mux_n #(.NUM_CH(NCH), .DATA_WIDTH_IN_BYTES(4), .ARB_MODE(1)) u_rr (
        .ACLK(clk), .ARESETn(rst_n),
        .s_axis_tdata_sel(sel_data[1]), .s_axis_tvalid_sel(sel_valid[1]), .s_axis_tready_sel(sel_ready[1]),
        .s_axis_tdata(s_tdata_f[1]), .s_axis_tvalid(s_tvalid_f[1]), .s_axis_tlast(s_tlast_f[1]),
        .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tlast(m_last[1]),
        .m_axis_tready(m_rdy[1]),
        .RDY(rdy[1]), .busy(busy[1]), .active_ch(act[1])
    );

    // Source drivers: present the head of each channel queue and pop it once it is accepted.
    for (genvar gd = 0; gd < 2; gd++) begin : g_dut
        for (genvar gc = 0; gc < NCH; gc++) begin : g_ch
            initial begin
                bit acc;
                ch_valid[gd][gc] = 1'b0;
                ch_data[gd][gc]  = '0;
                ch_last[gd][gc]  = 1'b0;
                forever begin
                    @(negedge clk);
                    acc = ch_valid[gd][gc] && s_tready[gd][gc];
                    @(posedge clk);
                    #1;
                    if (flush) begin
                        chq[gd][gc].delete();
                        ch_valid[gd][gc] = 1'b0;
                    end else begin
                        if (acc) begin
                            ch_valid[gd][gc] = 1'b0;
                            if (chq[gd][gc].size() > 0) void'(chq[gd][gc].pop_front());
                        end
                        if (!ch_valid[gd][gc] && chq[gd][gc].size() > 0 &&
                            $urandom_range(0, 99) >= gap_pct[gd]) begin
                            {ch_last[gd][gc], ch_data[gd][gc]} = chq[gd][gc][0];
                            ch_valid[gd][gc] = 1'b1;
                        end
                    end
                end
            end
        end
        initial begin
            m_rdy[gd] = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                case (mrdy_mode[gd])
                    0:       m_rdy[gd] = 1'b1;
                    1:       m_rdy[gd] = !m_rdy[gd];
                    default: m_rdy[gd] = ($urandom_range(0, 2) != 0);
                endcase
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, finished=0 required=1");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic monitor();
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    if (!$onehot0(s_tready[d])) begin
                        tests++;
                        fails++;
                        $display("FAIL tready_onehot dut%0d: got %b expected at most one bit", d, s_tready[d]);
                    end
                    if (prev_stall[d]) begin
                        tests++;
                        if (!m_valid[d] || m_data[d] !== prev_data[d] || m_last[d] !== prev_last[d]) begin
                            fails++;
                            $display("FAIL stall_hold dut%0d: got v=%0d d=%08h l=%0d expected v=1 d=%08h l=%0d",
                                     d, m_valid[d], m_data[d], m_last[d], prev_data[d], prev_last[d]);
                        end
                    end
                    if (m_valid[d] && m_rdy[d]) begin
                        tests++;
                        if (expq[d].size() == 0) begin
                            fails++;
                            $display("FAIL beat dut%0d: got d=%08h l=%0d expected no beat", d, m_data[d], m_last[d]);
                        end else begin
                            e = expq[d].pop_front();
                            if ({m_last[d], m_data[d]} !== e) begin
                                fails++;
                                $display("FAIL beat dut%0d: got d=%08h l=%0d expected d=%08h l=%0d",
                                         d, m_data[d], m_last[d], e[DW-1:0], e[DW]);
                            end else begin
                                $display("[TB] dut%0d beat d=%08h last=%0d", d, m_data[d], m_last[d]);
                            end
                        end
                    end
                    prev_stall[d] = m_valid[d] && !m_rdy[d];
                    prev_data[d]  = m_data[d];
                    prev_last[d]  = m_last[d];
                end
            end
        end
    endtask

    // Reference: a packet issued to a channel is forwarded whole, in order, with its tlast on the final beat.
    task automatic issue(input int d, input int c, input int len);
        logic [DW:0] b;
        for (int i = 0; i < len; i++) begin
            b = {(i == len - 1), 8'(c), 8'(pkt_id), 16'($urandom)};
            expq[d].push_back(b);
            chq[d][c].push_back(b);
        end
        pkt_id++;
    endtask

    task automatic write_sel(input int d, input logic [7:0] v);
        int  n = 0;
        bit  ok = 1'b0;
        sel_data[d]  = v;
        sel_valid[d] = 1'b1;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = sel_ready[d];
            @(posedge clk);
            #1;
            n++;
        end
        sel_valid[d] = 1'b0;
        chk("sel_handshake", ok, 1);
    endtask

    task automatic wait_idle(input int d, input string tag);
        int n    = 0;
        bit done = 1'b0;
        int pend;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
            pend = 0;
            for (int c = 0; c < NCH; c++) pend += chq[d][c].size();
            done = (expq[d].size() == 0) && (pend == 0) && !busy[d] && !m_valid[d] && sel_ready[d];
        end
        chk({tag, "_drain"}, done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        int  lat;
        int  k;
        bit  pb;
        for (int d = 0; d < 2; d++) begin
            sel_data[d]   = '0;
            sel_valid[d]  = 1'b0;
            gap_pct[d]    = 0;
            mrdy_mode[d]  = 0;
            prev_stall[d] = 1'b0;
            prev_data[d]  = '0;
            prev_last[d]  = 1'b0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", m_valid[0], 0);
        chk("rst_m_tlast", m_last[0], 0);
        chk("rst_m_tdata", m_data[0], 0);
        chk("rst_s_tready", s_tready[0], 0);
        chk("rst_rdy", rdy[0], 1);
        chk("rst_busy", busy[0], 0);
        chk("rst_active_ch", act[0], 0);
        chk("rst_tready_sel", sel_ready[0], 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_tready_sel", sel_ready[0], 1);
        chk("rel_tready_sel_rr", sel_ready[1], 1);
        chk("rel_rdy_rr", rdy[1], 1);

        // 1: 4-beat packet on ch0, latency and back-to-back output
        issue(0, 0, 4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ch_valid[0][0] && n < 100);
        lat = 0;
        while (!m_valid[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency", lat, 2);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("t1_back_to_back", m_valid[0], 1);
        end
        chk("t1_tlast", m_last[0], 1);
        @(posedge clk);
        #1;
        wait_idle(0, "t1");

        // 2: select write mid-packet is deferred until the packet ends
        issue(0, 0, 6);
        issue(0, 2, 5);
        n = 0;
        while (chq[0][0].size() > 4 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        write_sel(0, 8'd2);
        chk("t2_pend_full_tready_sel", sel_ready[0], 0);
        chk("t2_still_ch0", act[0], 0);
        wait_idle(0, "t2");

        // 3: alternating downstream backpressure
        mrdy_mode[0] = 1;
        issue(0, 2, 8);
        wait_idle(0, "t3");
        mrdy_mode[0] = 0;

        // 4: out-of-range select blocks grants until a valid select arrives
        write_sel(0, 8'd5);
        n = 0;
        while (rdy[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_rdy_low", rdy[0], 0);
        issue(0, 1, 3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_no_tready", s_tready[0], 0);
            chk("t4_no_tvalid", m_valid[0], 0);
        end
        @(posedge clk);
        #1;
        write_sel(0, 8'd1);
        n = 0;
        while (!rdy[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_rdy_back", rdy[0], 1);
        @(posedge clk);
        #1;
        wait_idle(0, "t4");

        // Randomized packets on randomly selected channels with random gaps and backpressure
        mrdy_mode[0] = 2;
        gap_pct[0]   = 30;
        for (int p = 0; p < 10; p++) begin
            k = $urandom_range(0, NCH - 1);
            write_sel(0, 8'(k));
            issue(0, k, $urandom_range(1, 8));
            wait_idle(0, "rand");
        end

        // 5: round-robin between two always-valid channels
        mrdy_mode[1] = 2;
        gap_pct[1]   = 0;
        for (int p = 0; p < 4; p++) begin
            issue(1, 1, 2);
            issue(1, 3, 2);
        end
        k  = 0;
        n  = 0;
        pb = busy[1];
        while (k < 8 && n < 2000) begin
            @(negedge clk);
            n++;
            if (busy[1] && !pb) begin
                chk("t5_grant", act[1], (k % 2 == 0) ? 1 : 3);
                k++;
            end
            pb = busy[1];
        end
        chk("t5_grants_seen", k, 8);
        @(posedge clk);
        #1;
        wait_idle(1, "t5");

        // 6: asynchronous reset mid-packet with the clock stopped
        mrdy_mode[0] = 1;
        gap_pct[0]   = 0;
        write_sel(0, 8'd3);
        issue(0, 3, 8);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_valid[0] && busy[0]) && n < 200);
        chk("t6_in_flight", m_valid[0] && busy[0], 1);
        clk_en = 1'b0;
        flush  = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("t6_m_tvalid", m_valid[0], 0);
        chk("t6_s_tready", s_tready[0], 0);
        chk("t6_rdy", rdy[0], 1);
        chk("t6_busy", busy[0], 0);
        expq[0].delete();
        expq[1].delete();
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
        #4 rst_n = 1'b1;
        #1 clk_en = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        chk("t6_idle_after", busy[0], 0);
        chk("t6_no_partial", m_valid[0], 0);
        chk("t6_active_ch", act[0], 0);
        mrdy_mode[0] = 0;
        @(posedge clk);
        #1;
        issue(0, 0, 3);
        wait_idle(0, "t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
